// File: rtl/store_byte_serializer.sv
// ---------------------------------------------------------------------------
// store_byte_serializer
//
// Narrows a 32-bit store operand to byte/half/word and writes it out
// little-endian on a byte-wide data-memory bus, one byte per accepted beat.
// It is the store-side inverse of the load path's sign extension: the upper
// operand bits beyond the selected size are dropped. It does not round or
// saturate them.
//
// Optional build macro: STORE_ALIGN_CHECK_EN
//   defined   - a misaligned half (addr[0]!=0) or word (addr[1:0]!=0) is
//               rejected with an err pulse. No beats are issued for it.
//   undefined - misaligned requests are serialized byte-wise. The address
//               wraps modulo 2^ADDR_WIDTH.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  store request handshake
//   req_addr             byte address of the least-significant byte
//   req_data             store operand (only the low 8/16/32 bits are used)
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   mem_valid/mem_ready  byte-beat handshake toward data memory
//   mem_addr, mem_wdata  current beat address and byte
//   busy                 a request is being serialized
//   done                 one-cycle pulse after the last beat is accepted
//   err                  one-cycle pulse when a request is rejected
// ---------------------------------------------------------------------------
module store_byte_serializer #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [1:0]            req_size,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [31:0]             data_r, data_s;
    logic [1:0]              idx_r, idx_s;
    logic [1:0]              last_r, last_s;
    logic                    done_r, done_s;
    logic                    err_r, err_s;
    logic                    reject_s;

    // Index of the final beat for a given size code (N-1).
    function automatic logic [1:0] last_index(input logic [1:0] size);
        logic [1:0] res;
        case (size)
            2'b00:   res = 2'd0;
            2'b01:   res = 2'd1;
            2'b10:   res = 2'd3;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    // Classify an incoming request as rejected (illegal size, or misaligned when checked).
    always_comb begin
        reject_s = 1'b0;
        if (req_size == 2'b11) begin
            reject_s = 1'b1;
        end else begin
`ifdef STORE_ALIGN_CHECK_EN
            if ((req_size == 2'b01) && (req_addr[0] != 1'b0)) begin
                reject_s = 1'b1;
            end else if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) begin
                reject_s = 1'b1;
            end else begin
                reject_s = 1'b0;
            end
`else
            reject_s = 1'b0;
`endif
        end
    end

    // Next-state and next-register logic. data_r keeps the not-yet-sent
    // bytes with the current byte at [7:0]. It shifts right one byte per accepted beat.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        data_s  = data_r;
        idx_s   = idx_r;
        last_s  = last_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (reject_s) begin
                        err_s = 1'b1;
                    end else begin
                        state_s = ST_SEND;
                        addr_s  = req_addr;
                        data_s  = req_data;
                        idx_s   = 2'd0;
                        last_s  = last_index(req_size);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (mem_ready) begin
                    if (idx_r == last_r) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        idx_s  = idx_r + 2'd1;
                        addr_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        data_s = {8'h00, data_r[31:8]};
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            data_r  <= 32'h0000_0000;
            idx_r   <= 2'd0;
            last_r  <= 2'd0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            idx_r   <= idx_s;
            last_r  <= last_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_SEND);
    assign mem_valid = (state_r == ST_SEND);
    assign mem_addr  = addr_r;
    assign mem_wdata = data_r[7:0];
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_store_byte_serializer.sv
// Self-checking bench for store_byte_serializer: a small reference model
// plus a beat scoreboard are checked every cycle in tick().
module tb_store_byte_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    store_byte_serializer #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        bit          last;
    } beat_t;

    beat_t sb_q[$];
    int    checks = 0;
    int    failures = 0;
    bit    m_busy = 1'b0;
    bit    done_due = 1'b0;
    bit    err_due = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model acceptance of the request currently on the req_* inputs.
    task automatic model_accept();
        int  n;
        bit  rej;
        beat_t b;
        n   = 1 << req_size;
        rej = (req_size == 2'b11);
`ifdef STORE_ALIGN_CHECK_EN
        if (req_size == 2'b01 && req_addr[0] != 1'b0) rej = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) rej = 1'b1;
`endif
        if (rej) begin
            err_due = 1'b1;
        end else begin
            for (int k = 0; k < n; k++) begin
                b.addr = req_addr + 32'(k);
                b.data = 8'((req_data >> (8 * k)) & 32'hFF);
                b.last = (k == n - 1);
                sb_q.push_back(b);
            end
            m_busy = 1'b1;
        end
    endtask

    // Check the current cycle at the falling edge, advance the model, then
    // move to just after the next rising edge.
    task automatic tick();
        beat_t b;
        @(negedge clk);
        if (!reset) begin
            chk("req_ready", req_ready, m_busy ? 32'd0 : 32'd1);
            chk("busy", busy, m_busy);
            chk("mem_valid", mem_valid, m_busy);
            chk("done", done, done_due);
            chk("err", err, err_due);
            done_due = 1'b0;
            err_due  = 1'b0;
            if (m_busy) begin
                chk("sb_nonempty", sb_q.size() != 0, 32'd1);
                if (sb_q.size() != 0) begin
                    b = sb_q[0];
                    chk("mem_addr", mem_addr, b.addr);
                    chk("mem_wdata", mem_wdata, b.data);
                    if (mem_ready) begin
                        void'(sb_q.pop_front());
                        if (b.last) begin
                            m_busy   = 1'b0;
                            done_due = 1'b1;
                        end
                    end
                end
            end else if (req_valid) begin
                model_accept();
            end
        end
        @(posedge clk);
        #1;
        if (reset) begin
            sb_q.delete();
            m_busy   = 1'b0;
            done_due = 1'b0;
            err_due  = 1'b0;
        end
    endtask

    // Present a request for one cycle, then scramble the inputs so that
    // capture (not pass-through) is exercised.
    task automatic send_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_req_ready", req_ready, 32'd1);
        chk("rst_mem_valid", mem_valid, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_err", err, 32'd0);
        reset = 1'b0;
        tick();

        // Word store, then a byte store accepted in the done cycle.
        mem_ready = 1'b1;
        send_req(32'h100, 32'hDEADBEEF, 2'b10);
        repeat (4) tick();
        chk("word_done_now", done, 32'd1);
        send_req(32'h2003, 32'h12345678, 2'b00);
        repeat (3) tick();

        // Half store with memory back-pressure: 3 stall cycles per beat.
        mem_ready = 1'b0;
        send_req(32'h40, 32'hAAAA1234, 2'b01);
        for (int beat = 0; beat < 2; beat++) begin
            repeat (3) tick();
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end
        mem_ready = 1'b1;
        repeat (2) tick();

        // Illegal size followed immediately by a legal byte.
        send_req(32'h10, 32'hFFFFFFFF, 2'b11);
        send_req(32'h55, 32'h000000A5, 2'b00);
        repeat (3) tick();

        // Word at the top of the address space (wrap or reject).
        send_req(32'hFFFFFFFE, 32'h04030201, 2'b10);
        repeat (6) tick();

        // Misaligned half.
        send_req(32'h201, 32'h0000BEEF, 2'b01);
        repeat (4) tick();

        // Reset while beat 2 of a word store is on the bus.
        send_req(32'h300, 32'h11223344, 2'b10);
        tick();
        tick();
        chk("pre_rst_addr", mem_addr, 32'h302);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_mem_valid", mem_valid, 32'd0);
        chk("abort_req_ready", req_ready, 32'd1);
        chk("abort_busy", busy, 32'd0);
        chk("abort_done", done, 32'd0);
        chk("abort_err", err, 32'd0);
        tick();
        send_req(32'h400, 32'hCAFE0077, 2'b00);
        repeat (3) tick();

        chk("sb_drained", sb_q.size(), 32'd0);
        chk("model_idle", m_busy, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_byte_serializer.md
Name: store_byte_serializer

Overview:
- Write-side counterpart of the load path's sign extension: the load path widens a narrow memory value to 32 bits, and this block narrows a 32-bit store operand to byte/half/word.
- Serializes the narrowed value little-endian onto the 8-bit data-memory write bus, one byte per accepted beat, under valid/ready handshakes on both sides.
- Sits between the execute stage's store request and the byte-wide data memory.

Parameters:
ADDR_WIDTH, 32, width of request and memory addresses; address arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
clk  input  1  clock; all logic updates on its rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  store request present
req_ready  output  1  block can accept a request
req_addr  input  ADDR_WIDTH  byte address of least-significant byte
req_data  input  32  store operand; only low 8/16/32 bits used
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
mem_valid  output  1  byte beat present on memory bus
mem_ready  input  1  memory accepts current beat
mem_addr  output  ADDR_WIDTH  address of current byte
mem_wdata  output  8  current byte
busy  output  1  high while a request is held (state SEND)
done  output  1  one-cycle pulse: all bytes of request written
err  output  1  one-cycle pulse: request rejected, no beats issued

Behaviour:
- Reset values: req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0. Internal index, data and address registers are cleared.
- Reset mid-transfer aborts the request: next cycle is IDLE with the reset values; no done or err pulse.
- States:
  - IDLE: req_ready=1.
  - SEND: req_ready=0, busy=1, mem_valid=1.
- Handshake is accepted when req_valid && req_ready. Address, data and size are captured into registers; later changes on the req_* inputs are ignored.
- Byte count N = 1 << req_size (1, 2 or 4).
- Legal request accepted at cycle T:
  - SEND begins at T+1, with mem_valid=1, mem_addr=req_addr and mem_wdata=data[7:0].
  - Beat k presents mem_addr = req_addr + k (wrapping) and mem_wdata = data[8k+7:8k].
- mem_addr and mem_wdata are registered and held stable while mem_valid && !mem_ready. The beat advances only when mem_valid && mem_ready.
- Last beat (k = N-1) accepted at cycle U:
  - At U+1: state IDLE, mem_valid=0, done=1 for one cycle, req_ready=1.
  - A new request may be accepted in that same U+1 cycle.
- With mem_ready held high, a request takes N+1 cycles from acceptance to the done pulse.
- Illegal size (11) accepted at T:
  - At T+1: err=1 for one cycle; state stays IDLE.
  - No beat is issued, no done pulse, req_ready remains 1.
- mem_valid never deasserts mid-request except on reset.
- done and err are never high in the same cycle.
- Upper data bits beyond N bytes are discarded (truncation, the inverse of sign extension). No rounding and no saturation.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- Defined:
  - Misaligned requests are rejected exactly like illegal size: err pulse at T+1, no beats.
  - A half is misaligned when req_addr[0]!=0; a word is misaligned when req_addr[1:0]!=0.
- Undefined: misaligned halves and words are accepted and serialized byte-wise, with address wrap across 2^ADDR_WIDTH.

Test Plan:
- Word store, req_data=0xDEADBEEF, req_addr=0x100, mem_ready=1 -> beats (0x100,EF), (0x101,BE), (0x102,AD), (0x103,DE) on consecutive cycles; done one cycle after the last beat; no err.
- Byte store, req_data=0x12345678, req_size=00, req_addr=0x2003 -> single beat (0x2003,0x78); done at T+2.
- Half store, req_data=0xAAAA1234, addr 0x40, mem_ready low for 3 cycles on each beat -> beat (0x40,34) held stable 4 cycles, then (0x41,12) held stable 4 cycles; req_ready=0 throughout; exactly one done pulse.
- req_size=11 -> err pulse at T+1; mem_valid stays 0; back-to-back legal byte request accepted at T+1 proceeds normally.
- Word at 0xFFFFFFFE:
  - Macro undefined -> addresses FE, FF, 00000000, 00000001.
  - STORE_ALIGN_CHECK_EN defined -> err pulse, no beats.
- reset asserted during beat 2 of a word store -> next cycle mem_valid=0, req_ready=1, busy=0, no done/err; a subsequent byte store completes correctly.
